// File: rtl/pkt_gen_reg_defines.sv
// Shared definitions for the packet generator register-ring master:
// ring field widths, FSM state encoding and the no-response read value.
package pkt_gen_reg_defines;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT     = 127;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] NO_RESPONSE = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/pkt_gen_reg_timer.sv
// Loadable down-counter with a zero flag; stops at zero.
// Used by pkt_gen_reg_master only when PKT_GEN_REG_MASTER_TIMEOUT_EN is defined.
module pkt_gen_reg_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pkt_gen_reg_master.sv
// Register-ring initiator: launches one host access at the ring head and
// waits for it at the tail. Timeout timer built when PKT_GEN_REG_MASTER_TIMEOUT_EN is defined.
module pkt_gen_reg_master
  import pkt_gen_reg_defines::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = DEFAULT_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           core_reg_req,
  input  logic                           core_reg_rd_wr_L,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic                           core_reg_ack,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic                           core_reg_err,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);

  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);

  state_t                         state;
  state_t                         state_next;
  logic                           is_read;
  logic [UDP_REG_ADDR_WIDTH-1:0]  addr_q;
  logic [CPCI_NF2_DATA_WIDTH-1:0] wr_data_q;
  logic [CPCI_NF2_DATA_WIDTH-1:0] result_q;
  logic [CPCI_NF2_DATA_WIDTH-1:0] result_d;
  logic                           err_q;
  logic                           err_d;
  logic                           issue;
  logic                           match;
  logic                           expired;

  // The tail echoes address and direction; only tag, ack and data matter here.
  logic unused_ring;
  assign unused_ring = ^{reg_rd_wr_L_in, reg_addr_in};

`ifdef PKT_GEN_REG_MASTER_TIMEOUT_EN
  logic [7:0] timer_load;
  logic       timer_zero;

  assign timer_load = 8'(TIMEOUT);

  pkt_gen_reg_timer #(
    .WIDTH(8)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (issue),
    .load_val(timer_load),
    .en      (state == ST_WAIT),
    .zero    (timer_zero)
  );

  assign expired = timer_zero;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  assign issue = (state == ST_ISSUE);
  assign match = reg_req_in && (reg_src_in == SRC_TAG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A matching return is checked before expiry so it wins a same-cycle tie.
  always_comb begin
    state_next = state;
    result_d   = result_q;
    err_d      = err_q;
    case (state)
      ST_IDLE:    if (core_reg_req) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (match) begin
          state_next = ST_RESPOND;
          if (reg_ack_in) begin
            result_d = is_read ? reg_data_in : '0;
            err_d    = 1'b0;
          end else begin
            result_d = is_read ? NO_RESPONSE : '0;
            err_d    = 1'b1;
          end
        end else if (expired) begin
          state_next = ST_RESPOND;
          result_d   = NO_RESPONSE;
          err_d      = 1'b1;
        end
      end
      ST_RESPOND: state_next = ST_HOLD;
      ST_HOLD:    if (!core_reg_req) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_read   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && core_reg_req) begin
        is_read   <= core_reg_rd_wr_L;
        addr_q    <= core_reg_addr;
        wr_data_q <= core_reg_wr_data;
      end
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign core_reg_ack     = (state == ST_RESPOND);
  assign core_reg_rd_data = result_q;
  assign core_reg_err     = err_q;

  // Ring head is quiet except for the single ISSUE cycle.
  assign reg_req_out     = issue;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = issue && is_read;
  assign reg_addr_out    = issue ? addr_q : '0;
  assign reg_data_out    = (issue && !is_read) ? wr_data_q : '0;
  assign reg_src_out     = issue ? SRC_TAG : '0;

endmodule
